muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit for the riscv_g23 core. It sits between the register file read ports (operands `rs1_data`/`rs2_data`) and its write port (`we`/`rd_addr`/`rd_data`). It accepts one M-extension operation and iterates one bit per cycle for 32 cycles. It then presents a single-cycle writeback strobe that drives the register file directly.

---
 rtl/muldiv_unit.sv | 151 +++++++++++++++
 tb/tb_muldiv_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
//------------------------------------------------------------------------------
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle, 32 cycles.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr_in,
  input  logic            flush,
  output logic            busy,
  output logic            wb_we,
  output logic [4:0]      wb_rd_addr,
  output logic [XLEN-1:0] wb_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state;
  logic [5:0]      cnt;
  logic [2:0]      op;
  logic [4:0]      rd;
  logic [XLEN-1:0] a_raw;
  logic [XLEN-1:0] b_mag;
  logic            a_neg;
  logic            res_neg;
  logic            b_zero;
  logic [63:0]     prod;
  logic [31:0]     quo;
  logic [32:0]     rem;
  logic            we_q;

  logic        a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
  logic [31:0] a_mag_in, b_mag_in;

  assign a_sgn_in = (funct3 == 3'b001) | (funct3 == 3'b010) |
                    (funct3 == 3'b100) | (funct3 == 3'b110);
  assign b_sgn_in = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
  assign a_neg_in = a_sgn_in & rs1_data[31];
  assign b_neg_in = b_sgn_in & rs2_data[31];
  assign a_mag_in = a_neg_in ? (~rs1_data + 32'd1) : rs1_data;
  assign b_mag_in = b_neg_in ? (~rs2_data + 32'd1) : rs2_data;

  // Shift-add: low half holds the remaining multiplier bits, high half accumulates.
  logic [32:0] mul_sum;
  logic [63:0] prod_nxt;
  assign mul_sum  = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, b_mag} : 33'd0);
  assign prod_nxt = {mul_sum, prod[31:1]};

  logic [32:0] div_sh;
  logic [33:0] div_diff;
  logic        div_ok;
  logic [32:0] rem_nxt;
  logic [31:0] quo_nxt;
  assign div_sh   = {rem[31:0], quo[31]};
  assign div_diff = {1'b0, div_sh} - {2'b00, b_mag};
  assign div_ok   = ~div_diff[33];
  assign rem_nxt  = div_ok ? div_diff[32:0] : div_sh;
  assign quo_nxt  = {quo[30:0], div_ok};

  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, result;
  assign prod_fix = res_neg ? (~prod_nxt + 64'd1) : prod_nxt;
  assign quo_fix  = res_neg ? (~quo_nxt + 32'd1) : quo_nxt;
  assign rem_fix  = a_neg ? (~rem_nxt[31:0] + 32'd1) : rem_nxt[31:0];

  always_comb begin
    result = prod_fix[31:0];
    case (op)
      3'b000:                 result = prod_fix[31:0];
      3'b001, 3'b010, 3'b011: result = prod_fix[63:32];
      3'b100, 3'b101:         result = b_zero ? 32'hFFFF_FFFF : quo_fix;
      default:                result = b_zero ? a_raw : rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 6'd0;
      op         <= 3'd0;
      rd         <= 5'd0;
      a_raw      <= '0;
      b_mag      <= '0;
      a_neg      <= 1'b0;
      res_neg    <= 1'b0;
      b_zero     <= 1'b0;
      prod       <= 64'd0;
      quo        <= 32'd0;
      rem        <= 33'd0;
      we_q       <= 1'b0;
      wb_rd_addr <= 5'd0;
      wb_data    <= '0;
    end else begin
      we_q <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            op      <= funct3;
            rd      <= rd_addr_in;
            a_raw   <= rs1_data;
            b_mag   <= b_mag_in;
            a_neg   <= a_neg_in;
            res_neg <= a_neg_in ^ b_neg_in;
            b_zero  <= (rs2_data == 32'd0);
            prod    <= {32'd0, a_mag_in};
            quo     <= a_mag_in;
            rem     <= 33'd0;
            cnt     <= 6'd0;
            state   <= S_CALC;
          end
          S_CALC: begin
            cnt <= cnt + 6'd1;
            if (op[2]) begin
              quo <= quo_nxt;
              rem <= rem_nxt;
            end else begin
              prod <= prod_nxt;
            end
            // Result is formed from the final iteration so it is registered for DONE.
            if (cnt == 6'd31) begin
              state      <= S_DONE;
              we_q       <= (rd != 5'd0);
              wb_rd_addr <= rd;
              wb_data    <= result;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy  = (state != S_IDLE);
  assign wb_we = we_q & ~flush;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
//------------------------------------------------------------------------------
// tb_muldiv_unit: directed and random checks of muldiv_unit against a reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic [4:0]  rd_addr_in = 5'd0;
  logic        busy, wb_we;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr_in(rd_addr_in),
    .flush(flush), .busy(busy), .wb_we(wb_we), .wb_rd_addr(wb_rd_addr),
    .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wb_we === 1'b1) pulses++;

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    int                 sa, sb;
    sa = a;
    sb = b;
    case (f)
      3'b000: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
      3'b001: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
      3'b010: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return sp[63:32]; end
      3'b011: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts an operation (caller is #1 after an edge), scrambles inputs during CALC,
  // optionally pulses start mid-CALC, and checks the DONE cycle and the cycle after.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit mid_start);
    int p0;
    logic [31:0] exp;
    exp = ref_model(f, a, b);
    funct3 = f; rs1_data = a; rs2_data = b; rd_addr_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rs1_data = $urandom; rs2_data = $urandom;
    funct3 = 3'($urandom); rd_addr_in = 5'($urandom);
    p0 = pulses;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    for (int i = 1; i <= 32; i++) begin
      if (mid_start && i == 5) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("no_early_we", 64'(pulses - p0), 64'd0);
    chk("done_busy", {63'd0, busy}, 64'd1);
    chk("done_we", {63'd0, wb_we}, {63'd0, (rd != 5'd0)});
    chk("done_rd", {59'd0, wb_rd_addr}, {59'd0, rd});
    chk("done_data", {32'd0, wb_data}, {32'd0, exp});
    @(posedge clk); #1;
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("idle_we", {63'd0, wb_we}, 64'd0);
    chk("hold_data", {32'd0, wb_data}, {32'd0, exp});
    chk("pulse_count", 64'(pulses - p0), (rd != 5'd0) ? 64'd1 : 64'd0);
  endtask

  initial begin
    int p0;
    logic [31:0] a, b;
    logic [2:0]  f;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_we", {63'd0, wb_we}, 64'd0);
    chk("rst_rd", {59'd0, wb_rd_addr}, 64'd0);
    chk("rst_data", {32'd0, wb_data}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'b000, 32'd7, 32'd6, 5'd5, 1'b0);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
    run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b0);
    for (int k = 4; k < 8; k++) run_op(3'(k), 32'hFFFF_FFF9, 32'd0, 5'd10, 1'b0);
    run_op(3'b101, 32'd100, 32'd7, 5'd11, 1'b1);
    run_op(3'b000, 32'd3, 32'd3, 5'd0, 1'b0);

    // Flush at CALC cycle 10, then an immediate new start.
    funct3 = 3'b000; rs1_data = 32'd9; rs2_data = 32'd9; rd_addr_in = 5'd12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    p0 = pulses;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_we", {63'd0, wb_we}, 64'd0);
    run_op(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13, 1'b0);
    chk("flush_pulses", 64'(pulses - p0), 64'd1);

    // Flush during DONE suppresses the strobe in that same cycle.
    funct3 = 3'b000; rs1_data = 32'd5; rs2_data = 32'd5; rd_addr_in = 5'd14; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    chk("done_we_pre_flush", {63'd0, wb_we}, 64'd1);
    flush = 1'b1;
    #1;
    chk("done_we_flushed", {63'd0, wb_we}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("done_flush_busy", {63'd0, busy}, 64'd0);

    // Reset at CALC cycle 20.
    funct3 = 3'b100; rs1_data = 32'd1000; rs2_data = 32'd10; rd_addr_in = 5'd15; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    p0 = pulses;
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_we", {63'd0, wb_we}, 64'd0);
    chk("mid_rst_rd", {59'd0, wb_rd_addr}, 64'd0);
    chk("mid_rst_data", {32'd0, wb_data}, 64'd0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_rst_no_wb", 64'(pulses - p0), 64'd0);
    run_op(3'b110, 32'hFFFF_FC18, 32'd7, 5'd16, 1'b0);

    for (int n = 0; n < 24; n++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        1: b = 32'd0;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(f, a, b, 5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
